burst_ram_arbiter: RTL and testbench

//  Shares one BurstRAM command/data port between two requesters: m0 (instruction cache) and m1 (data cache).

---
 rtl/burst_ram_arbiter_pkg.sv | 28 ++
 rtl/burst_ram_arbiter_starve_pick.sv | 43 ++++
 rtl/burst_ram_arbiter.sv | 159 +++++++++++++++
 tb/tb_burst_ram_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : burst_ram_arbiter_pkg
//  Description : Shared state encodings and command codes for the BurstRAM
//                two-requester arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package burst_ram_arbiter_pkg;

    // One-hot arbiter phases: wait for a request, issue the command,
    // move the beats, then let the RAM settle.
    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_ISSUE = 4'b0010,
        ST_XFER  = 4'b0100,
        ST_DRAIN = 4'b1000
    } state_t;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    // A burst owns the RAM while its command issues and its beats move.
    function automatic logic is_burst_active(input state_t s);
        return (s == ST_ISSUE) || (s == ST_XFER);
    endfunction

endpackage
`default_nettype wire

// File: rtl/burst_ram_arbiter_starve_pick.sv
`default_nettype none
// ============================================================================
//  Module      : arb_starve_pick
//  Description : Fixed-priority pick favouring m1, overridden in favour of m0
//                once m1 has been granted STARVE_LIMIT times in a row while
//                m0 was waiting.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_starve_pick
    import burst_ram_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_m0_req,
    input  logic i_m1_req,
    input  logic i_grant,      // a grant is taken this cycle
    output logic o_pick_m1     // 1: m1 wins, 0: m0 wins
);

    localparam int                 c_CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

    logic [c_CNT_W-1:0] r_starve_cnt;

    assign o_pick_m1 = i_m1_req && !(i_m0_req && (r_starve_cnt >= c_LIMIT));

    // Count m1 wins that made m0 wait; an m0 win resets the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (i_grant) begin
            if (!o_pick_m1) begin
                r_starve_cnt <= '0;
            end else if (i_m0_req && (r_starve_cnt != c_LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/burst_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : burst_ram_arbiter
//  Description : Shares one BurstRAM command/data port between the instruction
//                cache (m0, read only) and the data cache (m1, read/write).
//                Each grant covers one complete burst.
//  Revision    : 1.0 - initial release
// ============================================================================
module burst_ram_arbiter
    import burst_ram_arbiter_pkg::*;
#(
    parameter int RAM_DEPTH_BITWIDTH      = 4,
    parameter int RAM_BURST_DATA_BITWIDTH = 64,
    parameter int RAM_BURST_DATA_COUNT    = 4,
    parameter int STARVE_LIMIT            = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 m0_req,
    input  logic [RAM_DEPTH_BITWIDTH-1:0]        m0_addr,
    output logic                                 m0_gnt,
    output logic                                 m0_rd_valid,
    output logic                                 m0_done,
    input  logic                                 m1_req,
    input  logic                                 m1_cmd,
    input  logic [RAM_DEPTH_BITWIDTH-1:0]        m1_addr,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   m1_wr_data,
    input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] m1_data_mask,
    output logic                                 m1_wr_next,
    output logic                                 m1_gnt,
    output logic                                 m1_rd_valid,
    output logic                                 m1_done,
    output logic                                 br_cmd,
    output logic                                 br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
    output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
    input  logic                                 br_rd_data_valid,
    input  logic                                 br_busy
);

    localparam int                  c_BEAT_W    = $clog2(RAM_BURST_DATA_COUNT);
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(RAM_BURST_DATA_COUNT - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic                r_m0_gnt;
    logic                r_m1_gnt;
    logic                r_is_write;
    logic [c_BEAT_W-1:0] r_beat_cnt;

    logic w_active;
    logic w_grant;
    logic w_pick_m1;
    logic w_rd_beat;
    logic w_last_beat;

    assign w_active    = is_burst_active(r_state);
    assign w_grant     = (r_state == ST_IDLE) && !br_busy && (m0_req || m1_req);
    // Read beats only count while a read burst owns the port.
    assign w_rd_beat   = br_rd_data_valid && w_active && !r_is_write;
    assign w_last_beat = (r_state == ST_XFER) && (r_beat_cnt == c_LAST_BEAT)
                         && (r_is_write || w_rd_beat);

    arb_starve_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .clk       (clk),
        .rst       (rst),
        .i_m0_req  (m0_req),
        .i_m1_req  (m1_req),
        .i_grant   (w_grant),
        .o_pick_m1 (w_pick_m1)
    );

    assign m0_gnt       = r_m0_gnt;
    assign m1_gnt       = r_m1_gnt;
    assign m0_rd_valid  = w_rd_beat && r_m0_gnt;
    assign m1_rd_valid  = w_rd_beat && r_m1_gnt;
    assign m1_wr_next   = r_m1_gnt && r_is_write && w_active && (r_beat_cnt != c_LAST_BEAT);
    assign br_wr_data   = r_m1_gnt ? m1_wr_data   : '0;
    assign br_data_mask = r_m1_gnt ? m1_data_mask : '0;

    // Phase register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next phase plus the command and completion strobes of each phase.
    always_comb begin
        w_state_next = r_state;
        br_cmd_en    = 1'b0;
        br_cmd       = CMD_READ;
        br_addr      = '0;
        m0_done      = 1'b0;
        m1_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                br_cmd_en    = 1'b1;
                br_cmd       = r_is_write ? CMD_WRITE : CMD_READ;
                br_addr      = r_m1_gnt ? m1_addr : m0_addr;
                w_state_next = ST_XFER;
            end
            ST_XFER: begin
                if (w_last_beat) begin
                    m0_done      = r_m0_gnt;
                    m1_done      = r_m1_gnt;
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!br_busy) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Ownership: taken when a request is granted, released on the last beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m0_gnt   <= 1'b0;
            r_m1_gnt   <= 1'b0;
            r_is_write <= 1'b0;
        end else if (w_grant) begin
            r_m0_gnt   <= !w_pick_m1;
            r_m1_gnt   <= w_pick_m1;
            r_is_write <= w_pick_m1 && (m1_cmd == CMD_WRITE);
        end else if (w_last_beat) begin
            r_m0_gnt   <= 1'b0;
            r_m1_gnt   <= 1'b0;
            r_is_write <= 1'b0;
        end
    end

    // Beat counter: every cycle of a write burst, every routed read valid;
    // it rolls over to zero on the last beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat_cnt <= '0;
        end else if ((r_is_write && w_active) || w_rd_beat) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_burst_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_burst_ram_arbiter
//  Description : Self-checking bench for burst_ram_arbiter with a burst-level
//                reference model and directed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_burst_ram_arbiter;

    localparam int AW    = 4;
    localparam int DW    = 64;
    localparam int N     = 4;
    localparam int LIMIT = 8;

    logic          clk;
    logic          rst;
    logic          m0_req;
    logic [AW-1:0] m0_addr;
    logic          m0_gnt, m0_rd_valid, m0_done;
    logic          m1_req, m1_cmd;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wr_data;
    logic [DW/8-1:0] m1_data_mask;
    logic          m1_wr_next, m1_gnt, m1_rd_valid, m1_done;
    logic          br_cmd, br_cmd_en;
    logic [AW-1:0] br_addr;
    logic [DW-1:0] br_wr_data;
    logic [DW/8-1:0] br_data_mask;
    logic          br_rd_data_valid, br_busy;

    int n_checks = 0;
    int n_err    = 0;

    burst_ram_arbiter #(
        .RAM_DEPTH_BITWIDTH      (AW),
        .RAM_BURST_DATA_BITWIDTH (DW),
        .RAM_BURST_DATA_COUNT    (N),
        .STARVE_LIMIT            (LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
        .m0_rd_valid(m0_rd_valid), .m0_done(m0_done),
        .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_addr(m1_addr),
        .m1_wr_data(m1_wr_data), .m1_data_mask(m1_data_mask),
        .m1_wr_next(m1_wr_next), .m1_gnt(m1_gnt),
        .m1_rd_valid(m1_rd_valid), .m1_done(m1_done),
        .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr),
        .br_wr_data(br_wr_data), .br_data_mask(br_data_mask),
        .br_rd_data_valid(br_rd_data_valid), .br_busy(br_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model + per-cycle compare ----------------
    int  ph     = 0;   // 0 waiting, 1 command cycle, 2 moving beats, 3 settling
    int  own    = 0;   // 0 nobody, 1 m0, 2 m1
    bit  wr     = 0;
    int  beats  = 0;   // beats already delivered in this burst
    int  starve = 0;
    int  cmd_en_cnt = 0;
    logic          last_cmd;
    logic [AW-1:0] last_addr;
    int  gnt_log[$];
    logic prev_g0 = 1'b0, prev_g1 = 1'b0;

    always @(negedge clk) begin : compare
        logic [8:0]      e_ctl;
        logic [AW-1:0]   e_addr;
        logic [DW-1:0]   e_wd;
        logic [DW/8-1:0] e_mk;
        bit act, rdv, dn, pick;
        e_ctl = '0; e_addr = '0; e_wd = '0; e_mk = '0;
        if (rst) begin
            ph = 0; own = 0; wr = 0; beats = 0; starve = 0;
        end else begin
            act = (ph == 1) || (ph == 2);
            rdv = br_rd_data_valid && act && !wr;
            dn  = act && (wr ? (ph == 2 && beats == N - 1) : (rdv && beats == N - 1));
            e_ctl = {own == 1 && act, own == 2 && act, ph == 1, ph == 1 && wr,
                     rdv && own == 1, rdv && own == 2, dn && own == 1, dn && own == 2,
                     own == 2 && wr && act && beats < N - 1};
            e_addr = (ph == 1) ? (own == 2 ? m1_addr : m0_addr) : '0;
            e_wd   = (own == 2 && act) ? m1_wr_data   : '0;
            e_mk   = (own == 2 && act) ? m1_data_mask : '0;
            case (ph)
                0: if (!br_busy && (m0_req || m1_req)) begin
                       pick = m1_req && !(m0_req && starve >= LIMIT);
                       own  = pick ? 2 : 1;
                       wr   = pick && m1_cmd;
                       if (!pick) starve = 0;
                       else if (m0_req && starve < LIMIT) starve++;
                       beats = 0;
                       ph    = 1;
                   end
                1, 2: if (dn) begin
                       ph = 3; own = 0; wr = 0; beats = 0;
                   end else begin
                       if (wr || rdv) beats++;
                       ph = 2;
                   end
                default: if (!br_busy) ph = 0;
            endcase
        end
        check("ctl{g0,g1,cen,cmd,rv0,rv1,d0,d1,wn}",
              {55'd0, m0_gnt, m1_gnt, br_cmd_en, br_cmd, m0_rd_valid, m1_rd_valid,
               m0_done, m1_done, m1_wr_next}, {55'd0, e_ctl});
        check("br_addr", {60'd0, br_addr}, {60'd0, e_addr});
        check("br_wr_data", br_wr_data, e_wd);
        check("br_data_mask", {56'd0, br_data_mask}, {56'd0, e_mk});
        if (br_cmd_en) begin
            cmd_en_cnt++;
            last_cmd  = br_cmd;
            last_addr = br_addr;
        end
        if (m0_gnt && !prev_g0) gnt_log.push_back(0);
        if (m1_gnt && !prev_g1) gnt_log.push_back(1);
        prev_g0 = m0_gnt;
        prev_g1 = m1_gnt;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One read burst for requester m; valids arrive with a one-cycle gap.
    task automatic do_read(input int m, input logic [AW-1:0] a, output int done_at,
                           output int own_cnt, output int other_cnt, output bit granted);
        logic [7:0] pat;
        pat = 8'b0001_1101;
        done_at = 0; own_cnt = 0; other_cnt = 0; granted = 0;
        if (m == 0) begin m0_req = 1; m0_addr = a; end
        else begin m1_req = 1; m1_cmd = 0; m1_addr = a; end
        br_rd_data_valid = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if ((m == 0) ? m0_gnt : m1_gnt) begin granted = 1; break; end
            tick();
        end
        if (granted) begin
            for (int k = 0; k < 8; k++) begin
                tick();
                br_rd_data_valid = pat[k];
                @(negedge clk);
                if (m == 0) begin own_cnt += int'(m0_rd_valid); other_cnt += int'(m1_rd_valid); end
                else        begin own_cnt += int'(m1_rd_valid); other_cnt += int'(m0_rd_valid); end
                if ((m == 0) ? m0_done : m1_done) begin done_at = own_cnt; break; end
            end
        end
        tick();
        m0_req = 0; m1_req = 0; br_rd_data_valid = 0;
        tick(); tick();
    endtask

    // ---------------- directed scenarios ----------------
    initial begin : stim
        logic [DW-1:0] wbeat [4];
        logic [DW-1:0] seen_wd[$];
        int done_at, oc, xc, c0, idx, done_idx, seen;
        bit granted, nxt, fin;
        wbeat[0] = 64'hA0A0_0000_1111_00A0;
        wbeat[1] = 64'hA1A1_0000_2222_00A1;
        wbeat[2] = 64'hA2A2_0000_3333_00A2;
        wbeat[3] = 64'hA3A3_0000_4444_00A3;

        rst = 1; m0_req = 0; m0_addr = 0; m1_req = 0; m1_cmd = 0; m1_addr = 0;
        m1_wr_data = 0; m1_data_mask = 0; br_rd_data_valid = 0; br_busy = 0;
        tick(); tick();
        @(negedge clk);
        check("reset_outputs", {60'd0, m0_gnt, m1_gnt, br_cmd_en, m0_done}, 64'd0);
        tick();
        rst = 0;
        tick();

        // 1: m0 read alone
        c0 = cmd_en_cnt;
        do_read(0, 4'd3, done_at, oc, xc, granted);
        check("t1_granted", granted, 1);
        check("t1_cmd_en_count", cmd_en_cnt - c0, 1);
        check("t1_cmd", last_cmd, 0);
        check("t1_addr", last_addr, 3);
        check("t1_m0_rd_valid_count", oc, 4);
        check("t1_done_on_beat", done_at, 4);
        check("t1_m1_rd_valid_count", xc, 0);

        // 2: m1 write of four beats
        c0 = cmd_en_cnt;
        idx = 0; done_idx = -1; granted = 0;
        m1_req = 1; m1_cmd = 1; m1_addr = 5; m1_wr_data = wbeat[0]; m1_data_mask = 8'h01;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (m1_gnt) begin granted = 1; break; end
            tick();
        end
        for (int k = 0; k < 8 && granted; k++) begin
            seen_wd.push_back(br_wr_data);
            if (m1_done) begin done_idx = idx; break; end
            nxt = m1_wr_next;
            tick();
            if (nxt && idx < 3) begin
                idx++;
                m1_wr_data   = wbeat[idx];
                m1_data_mask = 8'h01 << idx;
            end
            @(negedge clk);
        end
        tick();
        m1_req = 0; m1_cmd = 0; m1_wr_data = 0; m1_data_mask = 0;
        tick(); tick();
        check("t2_granted", granted, 1);
        check("t2_cmd_en_count", cmd_en_cnt - c0, 1);
        check("t2_cmd", last_cmd, 1);
        check("t2_addr", last_addr, 5);
        check("t2_done_beat", done_idx, 3);
        check("t2_beats_seen", seen_wd.size(), 4);
        for (int i = 0; i < 4; i++)
            check("t2_wr_beat", (i < seen_wd.size()) ? seen_wd[i] : 64'd0, wbeat[i]);

        // 3: both requesting continuously
        gnt_log.delete();
        fin = 0;
        m0_req = 1; m0_addr = 1; m1_req = 1; m1_cmd = 0; m1_addr = 2;
        for (int c = 0; c < 400; c++) begin
            br_rd_data_valid = m0_gnt | m1_gnt;
            @(negedge clk);
            if ((m0_done | m1_done) && gnt_log.size() >= 18) begin fin = 1; break; end
            tick();
        end
        tick();
        m0_req = 0; m1_req = 0; br_rd_data_valid = 0;
        tick(); tick();
        check("t3_finished", fin, 1);
        check("t3_grant_count", gnt_log.size(), 18);
        for (int i = 0; i < 18; i++)
            check("t3_grant_owner", (i < gnt_log.size()) ? gnt_log[i] : -1,
                  ((i % 9) == 8) ? 0 : 1);

        // 4: br_busy blocks all grants
        br_busy = 1; m0_req = 1; m1_req = 1; m1_cmd = 0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            seen += int'(m0_gnt | m1_gnt | br_cmd_en);
            tick();
        end
        check("t4_blocked", seen, 0);
        br_busy = 0;
        @(negedge clk);
        check("t4_no_gnt_same_cycle", {m0_gnt, m1_gnt}, 2'b00);
        tick();
        @(negedge clk);
        check("t4_m1_gnt_next", {m0_gnt, m1_gnt}, 2'b01);
        fin = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            br_rd_data_valid = m0_gnt | m1_gnt;
            @(negedge clk);
            if (m0_done | m1_done) begin fin = 1; break; end
        end
        check("t4_burst_done", fin, 1);
        tick();
        m0_req = 0; m1_req = 0; br_rd_data_valid = 0;
        tick(); tick();

        // 5: reset during the transfer, then a fresh burst
        m0_req = 1; m0_addr = 9; granted = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (m0_gnt) begin granted = 1; break; end
            tick();
        end
        check("t5_granted", granted, 1);
        tick(); br_rd_data_valid = 1;
        tick(); br_rd_data_valid = 1;
        tick(); br_rd_data_valid = 0; rst = 1;
        @(negedge clk);
        check("t5_outputs_in_reset",
              {55'd0, m0_gnt, m1_gnt, br_cmd_en, m0_rd_valid, m0_done, m1_done,
               m1_wr_next, |br_addr, |br_wr_data}, 64'd0);
        tick();
        rst = 0;
        do_read(0, 4'd9, done_at, oc, xc, granted);
        check("t5_fresh_done_on_beat", done_at, 4);
        check("t5_fresh_rd_count", oc, 4);

        // 6: spurious valids while idle, then an m1 read
        br_rd_data_valid = 1;
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            seen += int'(m0_rd_valid | m1_rd_valid | m0_done | m1_done);
            tick();
        end
        br_rd_data_valid = 0;
        check("t6_spurious_ignored", seen, 0);
        do_read(1, 4'd10, done_at, oc, xc, granted);
        check("t6_m1_done_on_beat", done_at, 4);
        check("t6_m0_rd_valid_count", xc, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

endmodule
`default_nettype wire
